// File: rtl/led_matrix_driver.sv
// led_matrix_driver: multiplexed 4x4 LED grid driver with playhead inversion, PWM and a double-buffered pattern
// Ports: clk/rst_n (sync active-low); pattern_in/pattern_valid/pattern_ready load a 16-bit pattern (bit = row*4+col);
//        playhead/playhead_en invert one LED; brightness sets duty; row_outputs (active-low), col_outputs (active-high);
//        frame_start pulses on the first output cycle of row 0.
module led_matrix_driver #(
  parameter int ROW_PERIOD   = 65536,
  parameter int BLANK_CYCLES = 16,
  parameter int PWM_BITS     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         pattern_in,
  input  logic                pattern_valid,
  output logic                pattern_ready,
  input  logic [3:0]          playhead,
  input  logic                playhead_en,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [3:0]          row_outputs,
  output logic [3:0]          col_outputs,
  output logic                frame_start
);
  localparam int CW = $clog2(ROW_PERIOD);
  logic [CW-1:0] slot_cnt;
  logic [1:0]    row;
  logic [15:0]   active, shadow;
  logic          pending, last, on, lit;
  logic [3:0]    base, flip, cols;
  always_comb begin
    last = slot_cnt == CW'(ROW_PERIOD - 1);
    on   = slot_cnt >= CW'(BLANK_CYCLES);
    lit  = slot_cnt[PWM_BITS-1:0] < brightness;
    base = active[{row, 2'b00} +: 4];
    flip = (playhead_en && playhead[3:2] == row) ? 4'd1 << playhead[1:0] : 4'd0;
    cols = (on && lit) ? base ^ flip : 4'd0;
  end
  // ready is simply "shadow empty"; a capture can never coincide with a commit since capture needs pending low
  assign pattern_ready = ~pending;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      row         <= 2'd0;
      active      <= 16'd0;
      shadow      <= 16'd0;
      pending     <= 1'b0;
      row_outputs <= 4'hf;
      col_outputs <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
      if (last) row <= row + 2'd1;
      if (pattern_valid && !pending) begin
        shadow  <= pattern_in;
        pending <= 1'b1;
      end else if (pending && last && row == 2'd3) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      row_outputs <= on ? ~(4'd1 << row) : 4'hf;
      col_outputs <= cols;
      frame_start <= row == 2'd0 && slot_cnt == '0;
    end
  end
endmodule

// File: tb/tb_led_matrix_driver.sv
// tb_led_matrix_driver: randomized and directed check of led_matrix_driver against a time-indexed reference model
module tb_led_matrix_driver;
  localparam int RP = 64, BL = 4, PB = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] pattern_in = 16'd0;
  logic        pattern_valid = 1'b0, playhead_en = 1'b0;
  logic [3:0]  playhead = 4'd0, brightness = 4'd0;
  logic        pattern_ready, frame_start;
  logic [3:0]  row_outputs, col_outputs;
  int checks = 0, passes = 0;
  int n = 0;
  logic [15:0] m_active = 16'd0, m_shadow = 16'd0;
  bit m_pending = 1'b0;
  led_matrix_driver #(.ROW_PERIOD(RP), .BLANK_CYCLES(BL), .PWM_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .pattern_in(pattern_in), .pattern_valid(pattern_valid),
    .pattern_ready(pattern_ready), .playhead(playhead), .playhead_en(playhead_en),
    .brightness(brightness), .row_outputs(row_outputs), .col_outputs(col_outputs),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask
  // n counts clocks since reset release; slot and row follow from it arithmetically
  task automatic cyc();
    logic [3:0] er, ec;
    logic ef;
    int slot, r;
    er = 4'hf; ec = 4'd0; ef = 1'b0;
    if (!rst_n) begin
      n = 0; m_active = 16'd0; m_shadow = 16'd0; m_pending = 1'b0;
    end else begin
      slot = n % RP;
      r = (n / RP) % 4;
      if (slot >= BL) er = 4'hf & ~(4'd1 << r);
      if (slot >= BL && (slot % (1 << PB)) < int'(brightness))
        for (int i = 0; i < 4; i++)
          ec[i] = m_active[r*4+i] ^ (playhead_en && int'(playhead) == r*4+i);
      ef = (n % (4*RP)) == 0;
      if (pattern_valid && !m_pending) begin
        m_shadow = pattern_in; m_pending = 1'b1;
      end else if (m_pending && r == 3 && slot == RP-1) begin
        m_active = m_shadow; m_pending = 1'b0;
      end
      n++;
    end
    @(posedge clk); #1;
    chk("row_outputs", 16'(row_outputs), 16'(er));
    chk("col_outputs", 16'(col_outputs), 16'(ec));
    chk("frame_start", 16'(frame_start), 16'(ef));
    chk("pattern_ready", 16'(pattern_ready), 16'(!m_pending));
  endtask
  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask
  task automatic offer(input logic [15:0] p);
    pattern_in = p; pattern_valid = 1'b1;
    cyc();
    pattern_valid = 1'b0;
  endtask
  // advance until the outputs just sampled reflect slot s of row r
  task automatic goto(input int s, input int r);
    int k = 0;
    do begin cyc(); k++; end
    while (!(((n-1) % RP) == s && (((n-1) / RP) % 4) == r) && k <= 4*RP);
    if (k > 4*RP) chk("goto_timeout", 16'd0, 16'd1);
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin
      pattern_in = 16'($urandom); pattern_valid = 1'($urandom); brightness = 4'($urandom);
      cyc();
    end
    pattern_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("fs_after_release", 16'(frame_start), 16'd1);
    run(4*RP - 1);
    cyc();
    chk("fs_period", 16'(frame_start), 16'd1);
    brightness = 4'd15;
    offer(16'h8421);
    run(8*RP);
    goto(20, 1); chk("p8421_r1", 16'(col_outputs), 16'h2);
    goto(20, 3); chk("p8421_r3", 16'(col_outputs), 16'h8);
    goto(15, 0); chk("pwm15_off", 16'(col_outputs), 16'h0);
    goto(31, 2); chk("row2_drive", 16'(row_outputs), 16'hb);
    offer(16'h00FF);
    chk("ready_low", 16'(pattern_ready), 16'd0);
    offer(16'hFF00);
    run(8*RP);
    goto(10, 0); chk("p00ff_r0", 16'(col_outputs), 16'hf);
    goto(10, 2); chk("p00ff_r2", 16'(col_outputs), 16'h0);
    offer(16'h0000);
    run(8*RP);
    playhead = 4'd5; playhead_en = 1'b1;
    goto(10, 1); chk("ph_zero_r1", 16'(col_outputs), 16'h2);
    goto(10, 0); chk("ph_zero_r0", 16'(col_outputs), 16'h0);
    offer(16'hFFFF);
    run(8*RP);
    goto(10, 1); chk("ph_ones_r1", 16'(col_outputs), 16'hd);
    playhead_en = 1'b0;
    brightness = 4'd0;
    run(4*RP);
    brightness = 4'd8;
    goto(7, 0); chk("b8_pwm7", 16'(col_outputs), 16'hf);
    goto(8, 0); chk("b8_pwm8", 16'(col_outputs), 16'h0);
    goto(5, 2);
    offer(16'h1234);
    rst_n = 1'b0;
    cyc();
    chk("midreset_row", 16'(row_outputs), 16'hf);
    chk("midreset_ready", 16'(pattern_ready), 16'd1);
    rst_n = 1'b1;
    goto(5, 0); chk("cleared_active", 16'(col_outputs), 16'h0);
    while (!((n % RP) == RP-1 && ((n / RP) % 4) == 3)) cyc();
    offer(16'hA5A5);
    chk("collide_ready", 16'(pattern_ready), 16'd0);
    goto(5, 0); chk("collide_not_yet", 16'(col_outputs), 16'h0);
    cyc();
    goto(5, 0); chk("collide_commit", 16'(col_outputs), 16'h5);
    for (int i = 0; i < 4000; i++) begin
      pattern_in = 16'($urandom);
      pattern_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) playhead = 4'($urandom);
      if ($urandom_range(0, 63) == 0) playhead_en = 1'($urandom);
      if ($urandom_range(0, 127) == 0) brightness = 4'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      cyc();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
